// File: rtl/lwe_pkg.sv
// rtl/lwe_pkg.sv - shared LWE types and arithmetic helpers
package lwe_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  function automatic int unsigned calc_delta(input int unsigned q, input int unsigned p);
    return q / p;
  endfunction

  // Both operands must already be reduced below q.
  function automatic longint unsigned mod_add_fn(input longint unsigned a,
                                                 input longint unsigned b,
                                                 input longint unsigned q);
    longint unsigned s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction

endpackage

// File: rtl/mod_add.sv
// rtl/mod_add.sv - combinational a+b mod q for a, b < q
module mod_add
  import lwe_pkg::*;
#(
  parameter int WIDTH   = 21,
  parameter int MODULUS = 1024
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = WIDTH'(mod_add_fn(64'(a), 64'(b), 64'(MODULUS)));

endmodule

// File: rtl/lwe_encrypt.sv
// rtl/lwe_encrypt.sv - LWE encryption: accumulate selected public-key rows, emit ciphertext
module lwe_encrypt
  import lwe_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int DIMENSION          = 1,
  parameter int BIG_N              = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  input  logic [BIG_N-1:0]            rand_bits,
  input  logic                        publickey_valid,
  input  logic [CIPHERTEXT_WIDTH-1:0] publickey_entry,
  output logic                        publickey_ready,
  output logic                        ciphertext_valid,
  output logic [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
  output logic [DIMENSION:0]          row,
  output logic                        busy,
  output logic                        done
);

  localparam int DELTA = int'(calc_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));
  localparam int NE    = DIMENSION + 1;
  localparam int JW    = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
  localparam int IW    = (BIG_N > 1) ? $clog2(BIG_N) : 1;
  localparam int CW    = CIPHERTEXT_WIDTH;

  state_t            state_q, state_d;
  logic [BIG_N-1:0]  r_q;
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;
  logic [JW-1:0]     k_q;
  logic [CW-1:0]     acc_q [NE];
  logic [CW-1:0]     sum   [NE];
  logic              beat;
  logic              last_beat;
  logic              last_emit;

  assign beat      = (state_q == ACCUM) && publickey_valid;
  assign last_beat = beat && (i_q == IW'(BIG_N - 1)) && (j_q == JW'(DIMENSION));
  assign last_emit = (state_q == EMIT) && (k_q == JW'(DIMENSION));

  for (genvar g = 0; g < NE; g++) begin : g_acc
    mod_add #(
      .WIDTH   (CW),
      .MODULUS (CIPHERTEXT_MODULUS)
    ) u_mod_add (
      .a   (acc_q[g]),
      .b   (publickey_entry),
      .sum (sum[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = EMIT;
      EMIT:    if (last_emit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      for (int e = 0; e < NE; e++) acc_q[e] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_q      <= rand_bits;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q[0] <= CW'((32'(plaintext) * DELTA) % CIPHERTEXT_MODULUS);
            for (int e = 1; e < NE; e++) acc_q[e] <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            // Only the coefficient currently addressed by j picks up the entry.
            for (int e = 0; e < NE; e++)
              if (r_q[i_q] && (j_q == JW'(e))) acc_q[e] <= sum[e];
            if (j_q == JW'(DIMENSION)) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        EMIT: k_q <= last_emit ? '0 : k_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign publickey_ready  = (state_q == ACCUM);
  assign busy             = (state_q != IDLE);
  assign ciphertext_valid = (state_q == EMIT);
  assign ciphertext_entry = (state_q == EMIT) ? acc_q[k_q] : '0;
  assign row              = (state_q == EMIT) ? (DIMENSION + 1)'(k_q) : '0;
  assign done             = last_emit;

endmodule

// File: tb/tb_lwe_encrypt.sv
// tb/tb_lwe_encrypt.sv - scoreboard bench for lwe_encrypt
module tb_lwe_encrypt;

  localparam int P     = 64;
  localparam int PW    = 6;
  localparam int Q     = 1024;
  localparam int CW    = 21;
  localparam int D     = 1;
  localparam int N     = 30;
  localparam int DELTA = Q / P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] plaintext = '0;
  logic [N-1:0]  rand_bits = '0;
  logic          publickey_valid = 1'b0;
  logic [CW-1:0] publickey_entry = '0;
  logic          publickey_ready;
  logic          ciphertext_valid;
  logic [CW-1:0] ciphertext_entry;
  logic [D:0]    row;
  logic          busy;
  logic          done;

  lwe_encrypt #(
    .PLAINTEXT_MODULUS  (P),
    .PLAINTEXT_WIDTH    (PW),
    .CIPHERTEXT_MODULUS (Q),
    .CIPHERTEXT_WIDTH   (CW),
    .DIMENSION          (D),
    .BIG_N              (N)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .plaintext        (plaintext),
    .rand_bits        (rand_bits),
    .publickey_valid  (publickey_valid),
    .publickey_entry  (publickey_entry),
    .publickey_ready  (publickey_ready),
    .ciphertext_valid (ciphertext_valid),
    .ciphertext_entry (ciphertext_entry),
    .row              (row),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int row;
    int entry;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   A[N][D+1];
  int   ct_cap[D+1];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_expected(input int m, input logic [N-1:0] r);
    exp_t e;
    longint s;
    for (int j = 0; j <= D; j++) begin
      s = (j == 0) ? longint'(m) * DELTA : 0;
      for (int i = 0; i < N; i++) if (r[i]) s += A[i][j];
      e.row   = j;
      e.entry = int'(s % Q);
      e.done  = (j == D);
      sb.push_back(e);
    end
  endtask

  task automatic run_enc(input string name, input int m, input logic [N-1:0] r,
                         input bit gap, input int busy_start_at, input int reset_at,
                         input int exp_first, input int exp_done);
    int t0, c, idx, first_seen, done_seen;
    exp_t e;
    idx = 0; first_seen = -1; done_seen = -1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b1; plaintext = PW'(m); rand_bits = r;
    publickey_valid = 1'b0;
    push_expected(m, r);
    forever begin
      @(negedge clk);
      c = cyc - t0;
      if (c == busy_start_at) begin
        start = 1'b1; plaintext = PW'(5); rand_bits = N'($urandom);
      end else begin
        start = 1'b0; plaintext = PW'($urandom); rand_bits = N'($urandom);
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({publickey_ready, ciphertext_valid, ciphertext_entry, row, busy, done} !== '0) begin
          n_err++;
          $display("FAIL %s reset_outputs: got ready=%b valid=%b entry=%0d row=%0d busy=%b done=%b, want all 0",
                   name, publickey_ready, ciphertext_valid, ciphertext_entry, row, busy, done);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        publickey_valid = 1'b0;
        return;
      end
      if (c == 1) begin
        n_vec++;
        if (publickey_ready !== 1'b1 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s ready_cycle1: got ready=%b busy=%b, want 1 1", name, publickey_ready, busy);
        end
      end
      if (done_seen >= 0 && c == done_seen + 1) begin
        n_vec++;
        if (busy !== 1'b0 || ciphertext_valid !== 1'b0 || publickey_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s idle_after_done: got busy=%b valid=%b ready=%b, want 0 0 0",
                   name, busy, ciphertext_valid, publickey_ready);
        end
        break;
      end
      if (ciphertext_valid === 1'b1) begin
        if (first_seen < 0) first_seen = c;
        if (row <= D) ct_cap[row] = int'(ciphertext_entry);
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_output: got row=%0d entry=%0d, want no output", name, row, ciphertext_entry);
        end else begin
          e = sb.pop_front();
          if (int'(row) !== e.row || int'(ciphertext_entry) !== e.entry || done !== e.done) begin
            n_err++;
            $display("FAIL %s ct: got row=%0d entry=%0d done=%b, want row=%0d entry=%0d done=%b",
                     name, row, ciphertext_entry, done, e.row, e.entry, e.done);
          end
        end
        if (done === 1'b1) done_seen = c;
      end
      if (c > 400) begin
        n_vec++; n_err++;
        $display("FAIL %s timeout: got no done by cycle %0d, want done", name, c);
        sb.delete();
        break;
      end
      publickey_valid = gap ? (c % 2 == 0) : 1'b1;
      if (idx < N * (D + 1)) publickey_entry = CW'(A[idx / (D + 1)][idx % (D + 1)]);
      else publickey_entry = CW'($urandom_range(0, Q - 1));
      if (publickey_valid && publickey_ready && idx < N * (D + 1)) idx++;
    end
    publickey_valid = 1'b0;
    n_vec++;
    if (first_seen !== exp_first || done_seen !== exp_done || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s timing: got first=%0d done=%0d left=%0d, want first=%0d done=%0d left=0",
               name, first_seen, done_seen, sb.size(), exp_first, exp_done);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= D; j++) A[i][j] = $urandom_range(0, Q - 1);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= D; j++) A[i][j] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({publickey_ready, ciphertext_valid, ciphertext_entry, row, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b valid=%b entry=%0d row=%0d busy=%b done=%b, want all 0",
               publickey_ready, ciphertext_valid, ciphertext_entry, row, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_message_only();
    fill_random();
    run_enc("message_only", 38, '0, 1'b0, -1, -1, 61, 62);
    n_vec++;
    if (ct_cap[0] !== 608 || ct_cap[1] !== 0) begin
      n_err++;
      $display("FAIL message_only_value: got (%0d,%0d), want (608,0)", ct_cap[0], ct_cap[1]);
    end
  endtask

  task automatic test_single_row();
    fill_random();
    A[0][0] = 100; A[0][1] = 200;
    run_enc("single_row", 0, N'(1), 1'b0, -1, -1, 61, 62);
    n_vec++;
    if (ct_cap[0] !== 100 || ct_cap[1] !== 200) begin
      n_err++;
      $display("FAIL single_row_value: got (%0d,%0d), want (100,200)", ct_cap[0], ct_cap[1]);
    end
  endtask

  task automatic test_wrap(input bit gap);
    fill_const(1000);
    if (gap) run_enc("gapped", 63, '1, 1'b1, -1, -1, 121, 122);
    else     run_enc("wrap",   63, '1, 1'b0, -1, -1, 61, 62);
    n_vec++;
    if (ct_cap[0] !== 288 || ct_cap[1] !== 304) begin
      n_err++;
      $display("FAIL wrap_value gap=%0b: got (%0d,%0d), want (288,304)", gap, ct_cap[0], ct_cap[1]);
    end
  endtask

  task automatic test_start_busy();
    fill_const(1000);
    run_enc("start_busy", 63, '1, 1'b0, 20, -1, 61, 62);
    n_vec++;
    if (ct_cap[0] !== 288 || ct_cap[1] !== 304) begin
      n_err++;
      $display("FAIL start_busy_value: got (%0d,%0d), want (288,304)", ct_cap[0], ct_cap[1]);
    end
  endtask

  task automatic test_reset_mid();
    fill_const(1000);
    run_enc("reset_mid", 63, '1, 1'b0, -1, 25, 61, 62);
    fill_random();
    run_enc("after_reset", 10, N'($urandom), 1'b0, -1, -1, 61, 62);
  endtask

  task automatic test_loopback();
    int s, m, a, e, dec;
    longint v;
    for (int t = 0; t < 4; t++) begin
      s = $urandom_range(0, Q - 1);
      m = $urandom_range(0, P - 1);
      for (int i = 0; i < N; i++) begin
        a = $urandom_range(0, Q - 1);
        e = $urandom_range(0, 2) - 1;
        A[i][1] = a;
        A[i][0] = int'(((longint'(s) * a + e) % Q + Q) % Q);
      end
      run_enc("loopback", m, N'($urandom), 1'b0, -1, -1, 61, 62);
      v = (longint'(ct_cap[0]) - longint'(s) * ct_cap[1]) % Q;
      if (v < 0) v += Q;
      dec = int'(((v + DELTA / 2) / DELTA) % P);
      n_vec++;
      if (dec !== m) begin
        n_err++;
        $display("FAIL loopback_%0d: got decrypted %0d, want %0d", t, dec, m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_message_only();
    test_single_row();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_start_busy();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lwe_encrypt.md
# lwe_encrypt

LWE public-key encryption stage that produces the ciphertext consumed by `decrypt`. It accepts one plaintext plus a BIG_N-bit random subset selector and streams in the BIG_N × (DIMENSION+1) public-key matrix. It accumulates the selected rows modulo CIPHERTEXT_MODULUS and adds the scaled message to coefficient 0. It then emits the DIMENSION+1 ciphertext entries one per cycle, using the same `row`/entry format that `decrypt` consumes.

## Interface
- PLAINTEXT_MODULUS, 64, plaintext modulus p
- PLAINTEXT_WIDTH, 6, plaintext bits
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; q % p == 0 required
- CIPHERTEXT_WIDTH, 21, ciphertext entry bits
- DIMENSION, 1, LWE dimension; ciphertext has DIMENSION+1 entries
- BIG_N, 30, public-key rows
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin encryption; sampled in IDLE only
- plaintext  in  PLAINTEXT_WIDTH  message m, latched on accepted start
- rand_bits  in  BIG_N  row-selection vector r, latched on accepted start
- publickey_valid  in  1  publickey_entry valid this cycle
- publickey_entry  in  CIPHERTEXT_WIDTH  A[i][j], value < q, row-major order
- publickey_ready  out  1  high in ACCUM; a beat transfers when valid && ready
- ciphertext_valid  out  1  ciphertext_entry/row valid
- ciphertext_entry  out  CIPHERTEXT_WIDTH  ciphertext coefficient c[row]
- row  out  DIMENSION+1  coefficient index, same encoding as `decrypt` row input
- busy  out  1  high in ACCUM or EMIT
- done  out  1  one-cycle pulse coincident with the last ciphertext entry

## Operation
- DELTA = q/p (16 at defaults). c[0] = (m·DELTA + Σ r[i]·A[i][0]) mod q. c[j] = (Σ r[i]·A[i][j]) mod q for j ≥ 1.
- States and transitions:
  - IDLE → ACCUM on start. On that cycle: latch m and r, acc[0] ← m·DELTA mod q, other acc ← 0, i ← 0, j ← 0.
  - ACCUM: on each transfer beat, if r[i] then acc[j] ← acc[j] + entry, with q subtracted if the sum is ≥ q. Then advance j; when j wraps past DIMENSION, j ← 0 and i increments.
  - ACCUM → EMIT on the beat with i = BIG_N-1 and j = DIMENSION.
  - EMIT: emit index k = 0..DIMENSION, one per cycle, with ciphertext_valid = 1, row = k, ciphertext_entry = acc[k]. No back-pressure.
  - EMIT → IDLE after k = DIMENSION. done is asserted on that same cycle.
- Ignored inputs:
  - start outside IDLE is ignored, with no effect on latched m/r.
  - publickey_valid outside ACCUM is ignored; the source must hold data.
- Accumulators hold values < q at all times. Upper CIPHERTEXT_WIDTH bits above log2-range are zero.
- Reset clears everything. All outputs go to 0 and state to IDLE, including mid-ACCUM or mid-EMIT; the partial result is discarded.

## Timing
- Outputs are driven from registers and state only; there is no combinational path from input to output.
- Start accepted at cycle 0 → publickey_ready from cycle 1.
- With continuous valid, the last beat is at cycle BIG_N·(DIMENSION+1), i.e. cycle 60 at defaults.
- First ciphertext_valid at cycle BIG_N·(D+1)+1, i.e. cycle 61; last ciphertext_valid and done at cycle 62; IDLE at cycle 63. start is accepted again at cycle 63.
- Each cycle with valid low during ACCUM delays everything by one cycle.
- busy is high from cycle 1 through the last EMIT cycle.

## Structure
- Shared package `lwe_pkg` contains:
  - state enum {IDLE, ACCUM, EMIT}
  - DELTA derivation function
  - modular-add helper
- `decrypt` also reuses the modular-add helper.
- One sub-module, `mod_add`: a combinational a+b mod q for a, b < q, instantiated once per accumulator.

## Test plan
- **Message only:** r = 0, m = 38, defaults. Expected ct = (608, 0) on rows 0, 1; done on row 1.
- **Single row:** r = 1, A[0] = (100, 200), other rows random, m = 0. Expected ct = (100, 200).
- **Wrap-around:** r = all ones, every A entry 1000, m = 63. Expected ct = (288, 304).
- **Gapped valid:** repeat the wrap-around case with publickey_valid toggling every cycle. Expected: same ct, first valid at cycle 121, done at cycle 122.
- **Start while busy:** pulse start with m = 5 mid-ACCUM. Expected: ignored, result unchanged from the original m.
- **Reset mid-ACCUM:** assert rst_n low mid-ACCUM. Expected: all outputs 0 immediately and state IDLE; a fresh start then yields the correct ct.
- **Loopback:** feed the ct with sk = (1, −s) and the corresponding A into `decrypt`. Expected: decrypt returns m across 4 random keys/messages.
